// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared widths, ALUOp/funct encodings and ALU operation decode for the execute stage
package ex_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ORI   = 2'b11;

    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_SRA  = 6'h03;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU = 6'h2B;

    // ALU_ADD/ALU_SUB are the overflow-reporting variants; the U forms never report
    typedef enum logic [3:0] {
        ALU_NONE,
        ALU_ADD,
        ALU_ADDU,
        ALU_SUB,
        ALU_SUBU,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLTU,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA
    } alu_op_e;

    function automatic alu_op_e decode_alu_op(input logic [1:0] alu_op, input logic [5:0] funct);
        alu_op_e op;
        op = ALU_NONE;
        case (alu_op)
            ALUOP_ADD: op = ALU_ADD;
            ALUOP_SUB: op = ALU_SUB;
            ALUOP_ORI: op = ALU_OR;
            default: begin
                case (funct)
                    FUNCT_ADD:  op = ALU_ADD;
                    FUNCT_ADDU: op = ALU_ADDU;
                    FUNCT_SUB:  op = ALU_SUB;
                    FUNCT_SUBU: op = ALU_SUBU;
                    FUNCT_AND:  op = ALU_AND;
                    FUNCT_OR:   op = ALU_OR;
                    FUNCT_XOR:  op = ALU_XOR;
                    FUNCT_NOR:  op = ALU_NOR;
                    FUNCT_SLT:  op = ALU_SLT;
                    FUNCT_SLTU: op = ALU_SLTU;
                    FUNCT_SLL:  op = ALU_SLL;
                    FUNCT_SRL:  op = ALU_SRL;
                    FUNCT_SRA:  op = ALU_SRA;
                    default:    op = ALU_NONE;
                endcase
            end
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ex_alu.sv
// rtl/ex_alu.sv - combinational ALU: (op, A, B, shamt) -> result, signed overflow
module ex_alu
    import ex_pkg::*;
(
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [4:0]      shamt_i,
    output logic [XLEN-1:0] result_o,
    output logic            ovf_o
);

    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;
    logic            add_ovf;
    logic            sub_ovf;

    assign sum     = a_i + b_i;
    assign diff    = a_i - b_i;
    // Signed overflow: operands agree in sign (add) or differ (sub) and the result sign flips
    assign add_ovf = (a_i[XLEN-1] == b_i[XLEN-1]) && (sum[XLEN-1]  != a_i[XLEN-1]);
    assign sub_ovf = (a_i[XLEN-1] != b_i[XLEN-1]) && (diff[XLEN-1] != a_i[XLEN-1]);

    // Result select; only the trapping add/sub variants raise ovf_o
    always_comb begin
        result_o = '0;
        ovf_o    = 1'b0;
        case (alu_op_e'(op_i))
            ALU_ADD: begin
                result_o = sum;
                ovf_o    = add_ovf;
            end
            ALU_ADDU: result_o = sum;
            ALU_SUB: begin
                result_o = diff;
                ovf_o    = sub_ovf;
            end
            ALU_SUBU: result_o = diff;
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_NOR:  result_o = ~(a_i | b_i);
            ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
            ALU_SLL:  result_o = b_i << shamt_i;
            ALU_SRL:  result_o = b_i >> shamt_i;
            ALU_SRA:  result_o = $unsigned($signed(b_i) >>> shamt_i);
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - execute stage with forwarding, ALU decode and EX/MEM register; EX_OVF_TRAP_EN enables overflow trap
module ex_mem_stage
    import ex_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic [REG_AW-1:0] rd,
    input  logic              Regdst,
    input  logic              ALUsrc,
    input  logic [1:0]        ALUOp,
    input  logic              MemRead,
    input  logic              MemtoReg,
    input  logic              MemWrite,
    input  logic              RegWrite,
    input  logic [XLEN-1:0]   Immediate,
    input  logic [XLEN-1:0]   read1,
    input  logic [XLEN-1:0]   read2,
    input  logic              wb_RegWrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic [XLEN-1:0]   alu_result,
    output logic [XLEN-1:0]   store_data,
    output logic [REG_AW-1:0] dst_reg,
    output logic              zero,
    output logic              MemReadout,
    output logic              MemtoRegout,
    output logic              MemWriteout,
    output logic              RegWriteout,
    output logic              ovf
);

`ifdef EX_OVF_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    logic [XLEN-1:0]   alu_q,      alu_d;
    logic [XLEN-1:0]   store_q,    store_d;
    logic [REG_AW-1:0] dst_q,      dst_d;
    logic              zero_q,     zero_d;
    logic              memread_q,  memread_d;
    logic              memtoreg_q, memtoreg_d;
    logic              memwrite_q, memwrite_d;
    logic              regwrite_q, regwrite_d;
    logic              ovf_q,      ovf_d;

    logic [XLEN-1:0]   fwd_rs;
    logic [XLEN-1:0]   fwd_rt;
    logic [XLEN-1:0]   op_b;
    logic [XLEN-1:0]   alu_res;
    logic              alu_ovf;
    logic              trap;
    alu_op_e           alu_op;

    // Operand forwarding: EX/MEM result first, then MEM/WB write-back, then register file
    always_comb begin
        fwd_rs = read1;
        if (regwrite_q && (dst_q != '0) && (dst_q == rs)) begin
            fwd_rs = alu_q;
        end else if (wb_RegWrite && (wb_rd != '0) && (wb_rd == rs)) begin
            fwd_rs = wb_data;
        end
        fwd_rt = read2;
        if (regwrite_q && (dst_q != '0) && (dst_q == rt)) begin
            fwd_rt = alu_q;
        end else if (wb_RegWrite && (wb_rd != '0) && (wb_rd == rt)) begin
            fwd_rt = wb_data;
        end
    end

    assign alu_op = decode_alu_op(ALUOp, Immediate[5:0]);

    // ori always takes the zero-extended low immediate, whatever ALUsrc says
    always_comb begin
        op_b = ALUsrc ? Immediate : fwd_rt;
        if (ALUOp == ALUOP_ORI) begin
            op_b = {{(XLEN-16){1'b0}}, Immediate[15:0]};
        end
    end

    ex_alu u_alu (
        .op_i     (alu_op),
        .a_i      (fwd_rs),
        .b_i      (op_b),
        .shamt_i  (Immediate[10:6]),
        .result_o (alu_res),
        .ovf_o    (alu_ovf)
    );

    // Next EX/MEM contents; a trapping instruction loses its register and memory writes
    always_comb begin
        trap       = TRAP_EN && alu_ovf;
        alu_d      = alu_res;
        store_d    = fwd_rt;
        dst_d      = Regdst ? rd : rt;
        zero_d     = (alu_res == '0);
        memread_d  = MemRead;
        memtoreg_d = MemtoReg;
        memwrite_d = MemWrite && !trap;
        regwrite_d = RegWrite && !trap;
        ovf_d      = trap;
    end

    // EX/MEM register: reset > flush (bubble, data held) > stall (hold) > advance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_q      <= '0;
            store_q    <= '0;
            dst_q      <= '0;
            zero_q     <= 1'b0;
            memread_q  <= 1'b0;
            memtoreg_q <= 1'b0;
            memwrite_q <= 1'b0;
            regwrite_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (flush) begin
            zero_q     <= 1'b0;
            memread_q  <= 1'b0;
            memtoreg_q <= 1'b0;
            memwrite_q <= 1'b0;
            regwrite_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (!stall) begin
            alu_q      <= alu_d;
            store_q    <= store_d;
            dst_q      <= dst_d;
            zero_q     <= zero_d;
            memread_q  <= memread_d;
            memtoreg_q <= memtoreg_d;
            memwrite_q <= memwrite_d;
            regwrite_q <= regwrite_d;
            ovf_q      <= ovf_d;
        end
    end

    assign alu_result  = alu_q;
    assign store_data  = store_q;
    assign dst_reg     = dst_q;
    assign zero        = zero_q;
    assign MemReadout  = memread_q;
    assign MemtoRegout = memtoreg_q;
    assign MemWriteout = memwrite_q;
    assign RegWriteout = regwrite_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - self-checking bench for ex_mem_stage with a behavioural reference model
module tb_ex_mem_stage;

`ifdef EX_OVF_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, stall, flush;
    logic [4:0]  rs, rt, rd;
    logic        Regdst, ALUsrc;
    logic [1:0]  ALUOp;
    logic        MemRead, MemtoReg, MemWrite, RegWrite;
    logic [31:0] Immediate, read1, read2;
    logic        wb_RegWrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] alu_result, store_data;
    logic [4:0]  dst_reg;
    logic        zero, MemReadout, MemtoRegout, MemWriteout, RegWriteout, ovf;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .rs(rs), .rt(rt), .rd(rd), .Regdst(Regdst), .ALUsrc(ALUsrc), .ALUOp(ALUOp),
        .MemRead(MemRead), .MemtoReg(MemtoReg), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .Immediate(Immediate), .read1(read1), .read2(read2),
        .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .alu_result(alu_result), .store_data(store_data), .dst_reg(dst_reg), .zero(zero),
        .MemReadout(MemReadout), .MemtoRegout(MemtoRegout), .MemWriteout(MemWriteout),
        .RegWriteout(RegWriteout), .ovf(ovf)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_alu, m_store;
    logic [4:0]  m_dst;
    logic        m_zero, m_mr, m_mtr, m_mw, m_rw, m_ovf;
    bit          m_data_ok;

    // Value an instruction sees for a source: previous instruction's result, else write-back, else register file
    function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] rf);
        if (m_rw && m_dst != 5'd0 && m_dst == src) return m_alu;
        if (wb_RegWrite && wb_rd != 5'd0 && wb_rd == src) return wb_data;
        return rf;
    endfunction

    function automatic bit sovf(input longint s);
        longint lmax = 64'sd2147483647;
        return (s > lmax) || (s < -lmax - 1);
    endfunction

    function automatic void ref_exec(input logic [1:0] op, input logic [31:0] imm,
                                     input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output bit ov);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 32'd0;
        ov = 1'b0;
        if (op == 2'b00) begin
            r = a + b; ov = sovf(sa + sb);
        end else if (op == 2'b01) begin
            r = a - b; ov = sovf(sa - sb);
        end else if (op == 2'b11) begin
            r = a | {16'h0000, imm[15:0]};
        end else begin
            case (imm[5:0])
                6'h20: begin r = a + b; ov = sovf(sa + sb); end
                6'h21: r = a + b;
                6'h22: begin r = a - b; ov = sovf(sa - sb); end
                6'h23: r = a - b;
                6'h24: r = a & b;
                6'h25: r = a | b;
                6'h26: r = a ^ b;
                6'h27: r = ~(a | b);
                6'h2A: r = (sa < sb) ? 32'd1 : 32'd0;
                6'h2B: r = (a < b) ? 32'd1 : 32'd0;
                6'h00: r = b << imm[10:6];
                6'h02: r = b >> imm[10:6];
                6'h03: r = 32'($signed(b) >>> imm[10:6]);
                default: r = 32'd0;
            endcase
        end
    endfunction

    always @(posedge clk) begin
        logic [31:0] a, b, opb, r;
        bit          t;
        if (!rst_n) begin
            m_alu = 0; m_store = 0; m_dst = 0; m_zero = 0;
            m_mr = 0; m_mtr = 0; m_mw = 0; m_rw = 0; m_ovf = 0; m_data_ok = 1'b1;
        end else if (flush) begin
            m_mr = 0; m_mtr = 0; m_mw = 0; m_rw = 0; m_zero = 0; m_ovf = 0; m_data_ok = 1'b0;
        end else if (!stall) begin
            a   = fwd(rs, read1);
            b   = fwd(rt, read2);
            opb = ALUsrc ? Immediate : b;
            ref_exec(ALUOp, Immediate, a, opb, r, t);
            t = t && TRAP;
            m_alu = r; m_store = b; m_dst = Regdst ? rd : rt; m_zero = (r == 32'd0);
            m_mr = MemRead; m_mtr = MemtoReg; m_mw = MemWrite && !t; m_rw = RegWrite && !t;
            m_ovf = t; m_data_ok = 1'b1;
        end
    end

    // Per-cycle compare; data outputs after a flush are unspecified and skipped
    always @(negedge clk) begin
        if (chk_en) begin
            check("m.RegWriteout", 32'(RegWriteout), 32'(m_rw));
            check("m.MemWriteout", 32'(MemWriteout), 32'(m_mw));
            check("m.MemReadout",  32'(MemReadout),  32'(m_mr));
            check("m.MemtoRegout", 32'(MemtoRegout), 32'(m_mtr));
            check("m.zero",        32'(zero),        32'(m_zero));
            check("m.ovf",         32'(ovf),         32'(m_ovf));
            if (m_data_ok) begin
                check("m.alu_result", alu_result,    m_alu);
                check("m.store_data", store_data,    m_store);
                check("m.dst_reg",    32'(dst_reg),  32'(m_dst));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic ins(input logic [1:0] op, input logic src, input logic dsel, input logic [31:0] imm,
                       input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                       input logic [31:0] r1, input logic [31:0] r2);
        ALUOp = op; ALUsrc = src; Regdst = dsel; Immediate = imm;
        rs = s; rt = t; rd = d; read1 = r1; read2 = r2;
        RegWrite = 1'b1; MemRead = 1'b0; MemtoReg = 1'b0; MemWrite = 1'b0;
        stall = 1'b0; flush = 1'b0; wb_RegWrite = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] functs [14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                               6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h3F};

    initial begin
        // reset with every input high
        rst_n = 1'b0; stall = 1'b1; flush = 1'b1;
        rs = '1; rt = '1; rd = '1; Regdst = 1'b1; ALUsrc = 1'b1; ALUOp = '1;
        MemRead = 1'b1; MemtoReg = 1'b1; MemWrite = 1'b1; RegWrite = 1'b1;
        Immediate = '1; read1 = '1; read2 = '1; wb_RegWrite = 1'b1; wb_rd = '1; wb_data = '1;
        cyc();
        chk_en = 1'b1;
        cyc();
        check("rst.alu_result",  alu_result, 32'd0);
        check("rst.store_data",  store_data, 32'd0);
        check("rst.dst_reg",     32'(dst_reg), 32'd0);
        check("rst.RegWriteout", 32'(RegWriteout), 32'd0);
        check("rst.MemWriteout", 32'(MemWriteout), 32'd0);
        check("rst.ovf",         32'(ovf), 32'd0);
        rst_n = 1'b1;

        // R-type add 5+7 -> r3
        ins(2'b10, 1'b0, 1'b1, 32'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
        cyc();
        check("radd.alu",  alu_result, 32'd12);
        check("radd.dst",  32'(dst_reg), 32'd3);
        check("radd.rw",   32'(RegWriteout), 32'd1);

        // r4 <- 0x10, then rs=4 with both EX/MEM and MEM/WB hitting
        ins(2'b00, 1'b1, 1'b0, 32'h0, 5'd5, 5'd4, 5'd0, 32'h10, 32'h0);
        cyc();
        check("fwd.setup", alu_result, 32'h10);
        ins(2'b00, 1'b1, 1'b0, 32'h1, 5'd4, 5'd6, 5'd0, 32'hDEAD, 32'h0);
        wb_RegWrite = 1'b1; wb_rd = 5'd4; wb_data = 32'h20;
        cyc();
        check("fwd.exmem_wins", alu_result, 32'h11);
        cyc();
        check("fwd.memwb_only", alu_result, 32'h21);

        // sra / slt / sltu
        ins(2'b10, 1'b0, 1'b1, 32'h103, 5'd7, 5'd8, 5'd9, 32'h0, 32'h80000000);
        cyc();
        check("sra.alu",   alu_result, 32'hF8000000);
        check("sra.store", store_data, 32'h80000000);
        ins(2'b10, 1'b0, 1'b1, 32'h2A, 5'd7, 5'd8, 5'd9, 32'hFFFFFFFF, 32'd1);
        cyc();
        check("slt.alu",   alu_result, 32'd1);
        Immediate = 32'h2B;
        cyc();
        check("sltu.alu",  alu_result, 32'd0);
        check("sltu.zero", 32'(zero), 32'd1);

        // stall holds for 3 cycles while inputs change
        ins(2'b00, 1'b1, 1'b0, 32'h5, 5'd1, 5'd2, 5'd0, 32'd1, 32'd1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("stall.zero", 32'(zero), 32'd1);
            check("stall.dst",  32'(dst_reg), 32'd9);
        end
        flush = 1'b1;
        cyc();
        check("flush.rw",   32'(RegWriteout), 32'd0);
        check("flush.zero", 32'(zero), 32'd0);

        // ori zero-extends, store forwards rt from EX/MEM
        ins(2'b11, 1'b1, 1'b0, 32'hFFFF8001, 5'd1, 5'd10, 5'd0, 32'h12340000, 32'h0);
        cyc();
        check("ori.alu", alu_result, 32'h12348001);
        ins(2'b00, 1'b1, 1'b0, 32'h4, 5'd0, 5'd10, 5'd0, 32'h100, 32'h0);
        MemWrite = 1'b1; RegWrite = 1'b0;
        cyc();
        check("sw.addr",  alu_result, 32'h104);
        check("sw.store", store_data, 32'h12348001);
        check("sw.mw",    32'(MemWriteout), 32'd1);

        // writes to r0 pass through but never forward
        ins(2'b00, 1'b1, 1'b0, 32'h0, 5'd2, 5'd0, 5'd0, 32'h55, 32'h0);
        cyc();
        check("r0.rw", 32'(RegWriteout), 32'd1);
        ins(2'b00, 1'b1, 1'b0, 32'h2, 5'd0, 5'd5, 5'd0, 32'h0, 32'h0);
        cyc();
        check("r0.nofwd", alu_result, 32'd2);
        ins(2'b00, 1'b1, 1'b0, 32'h8, 5'd0, 5'd17, 5'd0, 32'h200, 32'h0);
        MemRead = 1'b1; MemtoReg = 1'b1;
        cyc();
        check("lw.addr", alu_result, 32'h208);
        check("lw.mr",   32'(MemReadout), 32'd1);

        // signed overflow
        ins(2'b10, 1'b0, 1'b1, 32'h20, 5'd11, 5'd12, 5'd13, 32'h7FFFFFFF, 32'd1);
        cyc();
        check("add_ovf.ovf", 32'(ovf), 32'(TRAP));
        check("add_ovf.rw",  32'(RegWriteout), 32'(!TRAP));
        Immediate = 32'h21;
        cyc();
        check("addu.alu", alu_result, 32'h80000000);
        check("addu.ovf", 32'(ovf), 32'd0);
        ins(2'b01, 1'b0, 1'b0, 32'h0, 5'd11, 5'd12, 5'd0, 32'h80000000, 32'd1);
        cyc();
        check("sub_ovf.alu", alu_result, 32'h7FFFFFFF);
        check("sub_ovf.ovf", 32'(ovf), 32'(TRAP));

        // funct sweep, shamt 5
        for (int i = 0; i < 14; i++) begin
            ins(2'b10, 1'b0, 1'b1, {21'd0, 5'd5, functs[i]}, 5'd14, 5'd15, 5'd16,
                32'h800000F0, 32'h00000F0F);
            cyc();
        end
        check("bad_funct.alu", alu_result, 32'd0);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
